// File: rtl/lcd_text_writer.sv
// ============================================================================
// lcd_text_writer: turns a character stream into character-RAM writes with
// cursor tracking, line wrap, control codes and row/screen clears.
// Revision: 1.0
// ============================================================================
`default_nettype none

module lcd_text_writer #(
    parameter int NUM_COLUMNS = 80,
    parameter int NUM_ROWS    = 30
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       in_valid,
    input  logic [6:0] in_char,
    output logic       in_ready,
    output logic       wr_en,
    output logic [6:0] wr_column,
    output logic [5:0] wr_row,
    output logic [6:0] wr_char,
    output logic [6:0] cursor_column,
    output logic [5:0] cursor_row,
    output logic       busy
);

    localparam logic [6:0] LAST_COLUMN = 7'(NUM_COLUMNS - 1);
    localparam logic [5:0] LAST_ROW    = 6'(NUM_ROWS - 1);
    localparam logic [6:0] SPACE       = 7'h20;
    localparam logic [6:0] CODE_BS     = 7'h08;
    localparam logic [6:0] CODE_LF     = 7'h0A;
    localparam logic [6:0] CODE_FF     = 7'h0C;
    localparam logic [6:0] CODE_CR     = 7'h0D;

    typedef enum logic [1:0] {
        CLEAR_SCREEN = 2'd0,
        IDLE         = 2'd1,
        CLEAR_ROW    = 2'd2
    } state_t;

    state_t     state;
    logic [6:0] clear_column;
    logic [5:0] clear_row;
    logic [5:0] next_row;
    logic       accept;
    logic       printable;

    assign in_ready  = (state == IDLE);
    assign busy      = ~in_ready;
    assign accept    = in_valid && in_ready;
    assign printable = (in_char >= 7'h20) && (in_char <= 7'h7E);
    assign next_row  = (cursor_row == LAST_ROW) ? 6'd0 : cursor_row + 6'd1;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= CLEAR_SCREEN;
            clear_column  <= 7'd0;
            clear_row     <= 6'd0;
            cursor_column <= 7'd0;
            cursor_row    <= 6'd0;
            wr_en         <= 1'b0;
            wr_column     <= 7'd0;
            wr_row        <= 6'd0;
            wr_char       <= SPACE;
        end else begin
            wr_en <= 1'b0;
            case (state)
                CLEAR_SCREEN: begin
                    wr_en     <= 1'b1;
                    wr_column <= clear_column;
                    wr_row    <= clear_row;
                    wr_char   <= SPACE;
                    if (clear_column == LAST_COLUMN) begin
                        clear_column <= 7'd0;
                        if (clear_row == LAST_ROW) begin
                            clear_row <= 6'd0;
                            state     <= IDLE;
                        end else begin
                            clear_row <= clear_row + 6'd1;
                        end
                    end else begin
                        clear_column <= clear_column + 7'd1;
                    end
                end
                CLEAR_ROW: begin
                    // The cursor row cannot change while clearing, so it names the row.
                    wr_en     <= 1'b1;
                    wr_column <= clear_column;
                    wr_row    <= cursor_row;
                    wr_char   <= SPACE;
                    if (clear_column == LAST_COLUMN) begin
                        clear_column <= 7'd0;
                        state        <= IDLE;
                    end else begin
                        clear_column <= clear_column + 7'd1;
                    end
                end
                IDLE: begin
                    if (accept) begin
                        if (printable) begin
                            wr_en     <= 1'b1;
                            wr_column <= cursor_column;
                            wr_row    <= cursor_row;
                            wr_char   <= in_char;
                            if (cursor_column == LAST_COLUMN) begin
                                cursor_column <= 7'd0;
                                cursor_row    <= next_row;
                                clear_column  <= 7'd0;
                                state         <= CLEAR_ROW;
                            end else begin
                                cursor_column <= cursor_column + 7'd1;
                            end
                        end else begin
                            case (in_char)
                                CODE_LF: begin
                                    cursor_column <= 7'd0;
                                    cursor_row    <= next_row;
                                    clear_column  <= 7'd0;
                                    state         <= CLEAR_ROW;
                                end
                                CODE_CR: cursor_column <= 7'd0;
                                CODE_BS: begin
                                    if (cursor_column != 7'd0) begin
                                        cursor_column <= cursor_column - 7'd1;
                                    end
                                end
                                CODE_FF: begin
                                    cursor_column <= 7'd0;
                                    cursor_row    <= 6'd0;
                                    clear_column  <= 7'd0;
                                    clear_row     <= 6'd0;
                                    state         <= CLEAR_SCREEN;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                default: state <= CLEAR_SCREEN;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_lcd_text_writer.sv
// ============================================================================
// tb_lcd_text_writer: directed self-checking bench for lcd_text_writer (80x30).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_lcd_text_writer;

    localparam int NC = 80;
    localparam int NR = 30;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       in_valid;
    logic [6:0] in_char;
    logic       in_ready;
    logic       wr_en;
    logic [6:0] wr_column;
    logic [5:0] wr_row;
    logic [6:0] wr_char;
    logic [6:0] cursor_column;
    logic [5:0] cursor_row;
    logic       busy;

    int checks = 0;
    int errors = 0;

    lcd_text_writer #(.NUM_COLUMNS(NC), .NUM_ROWS(NR)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .in_valid      (in_valid),
        .in_char       (in_char),
        .in_ready      (in_ready),
        .wr_en         (wr_en),
        .wr_column     (wr_column),
        .wr_row        (wr_row),
        .wr_char       (wr_char),
        .cursor_column (cursor_column),
        .cursor_row    (cursor_row),
        .busy          (busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Full-screen clear: one write per cycle, row-major, in_ready rising with the last one.
    task automatic expect_clear_screen();
        int e0;
        e0 = errors;
        for (int r = 0; r < NR; r++) begin
            for (int c = 0; c < NC; c++) begin
                @(negedge clock);
                chk("clear_screen", {in_ready, wr_en, wr_column, wr_row, wr_char},
                    {(r == NR - 1) && (c == NC - 1), 1'b1, 7'(c), 6'(r), 7'h20});
                if (errors != e0) return;
            end
        end
        chk("clear_screen_cursor", {cursor_column, cursor_row}, {7'd0, 6'd0});
    endtask

    task automatic expect_clear_row(input int row);
        int e0;
        e0 = errors;
        for (int c = 0; c < NC; c++) begin
            @(negedge clock);
            chk("clear_row", {in_ready, wr_en, wr_column, wr_row, wr_char},
                {c == NC - 1, 1'b1, 7'(c), 6'(row), 7'h20});
            if (errors != e0) return;
        end
    endtask

    task automatic send(input logic [6:0] ch);
        in_valid = 1'b1;
        in_char  = ch;
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic check_noop(input string tag, input int col, input int row);
        chk(tag, {in_ready, wr_en, cursor_column, cursor_row}, {1'b1, 1'b0, 7'(col), 6'(row)});
    endtask

    initial begin
        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_char  = 7'h00;

        repeat (3) @(negedge clock);
        chk("reset_outputs", {in_ready, busy, wr_en, wr_column, wr_row, wr_char},
            {1'b0, 1'b1, 1'b0, 7'd0, 6'd0, 7'h20});
        chk("reset_cursor", {cursor_column, cursor_row}, {7'd0, 6'd0});

        reset_n = 1'b1;
        expect_clear_screen();
        @(negedge clock);
        chk("idle_after_clear", {in_ready, busy, wr_en}, {1'b1, 1'b0, 1'b0});

        send(7'h41);
        chk("char_A", {in_ready, wr_en, wr_column, wr_row, wr_char, cursor_column, cursor_row},
            {1'b1, 1'b1, 7'd0, 6'd0, 7'h41, 7'd1, 6'd0});
        @(negedge clock);
        chk("write_pulse_hold", {wr_en, wr_column, wr_row, wr_char}, {1'b0, 7'd0, 6'd0, 7'h41});

        send(7'h0D);
        check_noop("cr_home", 0, 0);

        // A full line of back-to-back characters wraps onto row 1 and clears it.
        for (int i = 0; i < NC; i++) begin
            in_valid = 1'b1;
            in_char  = 7'(33 + i);
            @(negedge clock);
            chk("line_write", {wr_en, wr_column, wr_row, wr_char}, {1'b1, 7'(i), 6'd0, 7'(33 + i)});
        end
        in_valid = 1'b0;
        chk("wrap_cursor", {in_ready, cursor_column, cursor_row}, {1'b0, 7'd0, 6'd1});
        expect_clear_row(1);

        for (int k = 2; k < NR; k++) begin
            send(7'h0A);
            chk("lf_cursor", {in_ready, wr_en, cursor_column, cursor_row}, {1'b0, 1'b0, 7'd0, 6'(k)});
            expect_clear_row(k);
        end

        for (int j = 0; j < 5; j++) begin
            send(7'(97 + j));
            chk("row29_write", {wr_en, wr_column, wr_row, wr_char}, {1'b1, 7'(j), 6'd29, 7'(97 + j)});
        end
        chk("cursor_5_29", {cursor_column, cursor_row}, {7'd5, 6'd29});

        send(7'h0A);
        chk("lf_wrap", {in_ready, wr_en, cursor_column, cursor_row}, {1'b0, 1'b0, 7'd0, 6'd0});
        expect_clear_row(0);

        for (int k = 1; k <= 3; k++) begin
            send(7'h0A);
            expect_clear_row(k);
        end

        send(7'h08);
        check_noop("bs_at_col0", 0, 3);
        send(7'h0D);
        check_noop("cr_noop", 0, 3);
        send(7'h07);
        check_noop("bel_ignored", 0, 3);
        send(7'h7F);
        check_noop("del_ignored", 0, 3);

        send(7'h78);
        send(7'h79);
        send(7'h08);
        check_noop("bs_decrement", 1, 3);
        send(7'h0D);
        check_noop("cr_after_bs", 0, 3);

        send(7'h0C);
        chk("ff_cursor", {in_ready, wr_en, cursor_column, cursor_row}, {1'b0, 1'b0, 7'd0, 6'd0});
        expect_clear_screen();
        @(negedge clock);
        chk("idle_after_ff", {in_ready, wr_en}, {1'b1, 1'b0});

        // Characters offered during a row clear must be ignored; reset then aborts it.
        send(7'h0A);
        in_valid = 1'b1;
        in_char  = 7'h51;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            chk("clear_row_busy", {in_ready, wr_en, wr_column, wr_row, wr_char, cursor_column, cursor_row},
                {1'b0, 1'b1, 7'(c), 6'd1, 7'h20, 7'd0, 6'd1});
        end
        #2;
        reset_n = 1'b0;
        #1;
        chk("reset_abort", {in_ready, busy, wr_en, wr_column, wr_row, wr_char, cursor_column, cursor_row},
            {1'b0, 1'b1, 1'b0, 7'd0, 6'd0, 7'h20, 7'd0, 6'd0});
        in_valid = 1'b0;
        repeat (3) @(negedge clock);
        chk("reset_hold", {wr_en, in_ready}, {1'b0, 1'b0});

        reset_n = 1'b1;
        expect_clear_screen();
        @(negedge clock);
        chk("idle_after_reset", {in_ready, busy, wr_en}, {1'b1, 1'b0, 1'b0});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
